fft_out_serializer: RTL and testbench

Output unloader for the 8-point FFT pipeline. Captures one parallel frame of eight signed complex bins from the final FFT stage in a single cycle. Streams the bins one per cycle over a valid/ready interface to downstream consumers (DMA, UART bridge, scope capture). It is the read-out end of the parallel bus that the butterfly stages write.

---
 rtl/fft_pkg.sv | 20 ++
 rtl/fft_out_serializer.sv | 116 +++++++++++
 tb/tb_fft_out_serializer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT pipeline: sizes, default data width,
// bin-index bit reversal and the output serializer state encoding.
// Pure declarations; no logic, no latency, no flow control.
package fft_pkg;

    localparam int N          = 8;
    localparam int LOG2N      = 3;
    localparam int DW_DEFAULT = 16;

    // Reverse the three index bits: 0,1,2,3,4,5,6,7 -> 0,4,2,6,1,5,3,7
    function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage : fft_pkg

// File: rtl/fft_out_serializer.sv
// Purpose: capture one parallel 8-bin complex frame and stream it one bin per beat.
// Latency: frame accepted at edge N presents its first bin in cycle N+1; 8 beats per frame.
// Backpressure: out_ready low freezes all outputs; in_ready opens only when idle or as the last beat leaves.
// Build option FFT_SER_BITREV_EN: emit bins in bit-reversed order instead of natural order.
module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int FCW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     xr0,
    input  logic [DW-1:0]     xr1,
    input  logic [DW-1:0]     xr2,
    input  logic [DW-1:0]     xr3,
    input  logic [DW-1:0]     xr4,
    input  logic [DW-1:0]     xr5,
    input  logic [DW-1:0]     xr6,
    input  logic [DW-1:0]     xr7,
    input  logic [DW-1:0]     xi0,
    input  logic [DW-1:0]     xi1,
    input  logic [DW-1:0]     xi2,
    input  logic [DW-1:0]     xi3,
    input  logic [DW-1:0]     xi4,
    input  logic [DW-1:0]     xi5,
    input  logic [DW-1:0]     xi6,
    input  logic [DW-1:0]     xi7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_re,
    output logic [DW-1:0]     out_im,
    output logic [LOG2N-1:0]  out_idx,
    output logic              out_last,
    output logic [FCW-1:0]    out_frame
);

    localparam logic [LOG2N-1:0] LAST_BEAT = LOG2N'(N - 1);

    logic [N-1:0][DW-1:0] re_q;
    logic [N-1:0][DW-1:0] im_q;
    logic [N-1:0][DW-1:0] re_in;
    logic [N-1:0][DW-1:0] im_in;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] cnt_q,   cnt_d;
    logic [FCW-1:0]   frame_q, frame_d;
    logic [LOG2N-1:0] sel;
    logic             accept;
    logic             beat;
    logic             last_beat;

    assign re_in = {xr7, xr6, xr5, xr4, xr3, xr2, xr1, xr0};
    assign im_in = {xi7, xi6, xi5, xi4, xi3, xi2, xi1, xi0};

    assign beat      = (state_q == STREAM) && out_ready;
    assign last_beat = beat && (cnt_q == LAST_BEAT);

    // A new frame may land while idle, or on the same edge the final beat departs (no bubble)
    assign in_ready = rst && ((state_q == IDLE) || last_beat);
    assign accept   = in_valid && in_ready;

`ifdef FFT_SER_BITREV_EN
    assign sel = bitrev3(cnt_q);
`else
    assign sel = cnt_q;
`endif

    assign out_valid = (state_q == STREAM);
    assign out_last  = out_valid && (cnt_q == LAST_BEAT);
    assign out_idx   = sel;
    assign out_re    = re_q[sel];
    assign out_im    = im_q[sel];
    assign out_frame = frame_q;

    // Next-state for the beat counter, state and frame sequence number
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        if (last_beat) begin
            frame_d = frame_q + {{(FCW-1){1'b0}}, 1'b1};
        end
        if (accept) begin
            state_d = STREAM;
            cnt_d   = '0;
        end else if (last_beat) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (beat) begin
            cnt_d   = cnt_q + 3'd1;
        end
    end

    // State registers and frame buffer; the buffer is cleared so reset drives zero data
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            frame_q <= '0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            if (accept) begin
                re_q <= re_in;
                im_q <= im_in;
            end
        end
    end

endmodule : fft_out_serializer

// File: tb/tb_fft_out_serializer.sv
// Scoreboard bench for fft_out_serializer: directed frames push expected beats,
// a negedge monitor pops and compares on every transfer and checks held beats under stall.
// Build option FFT_SER_BITREV_EN selects the bit-reversed expected order.
module tb_fft_out_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              out_ready;
    logic              out_valid;
    logic [15:0]       out_re;
    logic [15:0]       out_im;
    logic [2:0]        out_idx;
    logic              out_last;
    logic [7:0]        out_frame;
    logic [7:0][15:0]  fr_re;
    logic [7:0][15:0]  fr_im;

    fft_out_serializer #(.DW(16), .FCW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .xr0       (fr_re[0]),
        .xr1       (fr_re[1]),
        .xr2       (fr_re[2]),
        .xr3       (fr_re[3]),
        .xr4       (fr_re[4]),
        .xr5       (fr_re[5]),
        .xr6       (fr_re[6]),
        .xr7       (fr_re[7]),
        .xi0       (fr_im[0]),
        .xi1       (fr_im[1]),
        .xi2       (fr_im[2]),
        .xi3       (fr_im[3]),
        .xi4       (fr_im[4]),
        .xi5       (fr_im[5]),
        .xi6       (fr_im[6]),
        .xi7       (fr_im[7]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_frame (out_frame)
    );

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [2:0]  idx;
        logic        last;
        logic [7:0]  frame;
    } beat_t;

    beat_t      exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         order[8];
    logic [7:0] frame_seq;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Load bins: re_k = re0 + k*step, im_k = im0 - k
    task automatic make_frame(input int re0, input int step, input int im0);
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 16'(re0 + k * step);
            fr_im[k] = 16'(im0 - k);
        end
    endtask

    task automatic push_frame();
        beat_t b;
        for (int n = 0; n < 8; n++) begin
            b.idx   = 3'(order[n]);
            b.re    = fr_re[order[n]];
            b.im    = fr_im[order[n]];
            b.last  = (n == 7);
            b.frame = frame_seq;
            exp_q.push_back(b);
        end
        frame_seq = frame_seq + 8'd1;
    endtask

    // Hold in_valid until accepted; report stall cycles and out_last at the accepting cycle
    task automatic send_frame(output int waited, output logic last_at_accept);
        bit ok;
        ok = 0;
        waited = 0;
        last_at_accept = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                last_at_accept = out_last;
                push_frame();
                ok = 1;
                break;
            end
            waited++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        #1;
        if (!ok) chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_idx(input int idx);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid && out_idx == 3'(idx)) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("wait_idx_timeout", 0, 1);
    endtask

    // Monitor: compare every presented beat against the scoreboard head; pop on transfer
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("out_re",    out_re,    e.re);
                    chk("out_im",    out_im,    e.im);
                    chk("out_idx",   out_idx,   e.idx);
                    chk("out_last",  out_last,  e.last);
                    chk("out_frame", out_frame, e.frame);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        logic la;
`ifdef FFT_SER_BITREV_EN
        order[0] = 0; order[1] = 4; order[2] = 2; order[3] = 6;
        order[4] = 1; order[5] = 5; order[6] = 3; order[7] = 7;
`else
        for (int k = 0; k < 8; k++) order[k] = k;
`endif
        frame_seq = 8'd0;

        // Reset with a frame offered: it must be ignored
        rst       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        make_frame(555, 7, 33);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_out_idx",   out_idx,   0);
        chk("rst_out_re",    out_re,    0);
        chk("rst_out_im",    out_im,    0);
        chk("rst_out_frame", out_frame, 0);
        chk("rst_in_ready",  in_ready,  0);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("post_rst_no_frame", out_valid, 0);

        // Single frame: re = 100k, im = -k
        make_frame(0, 100, 0);
        send_frame(w, la);
        chk("latency_valid", out_valid, 1);
        chk("latency_idx",   out_idx,   order[0]);
        wait_drain();
        chk("single_idle_after", out_valid, 0);

        // Backpressure: stall 3 cycles while bin 2 is presented
        make_frame(0, 100, 0);
        send_frame(w, la);
        wait_idx(2);
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", in_ready, 0);
        end
        chk("stall_held_re", out_re, 200);
        out_ready = 1'b1;
        wait_drain();

        // Back-to-back: frame B offered through all of frame A
        make_frame(1000, 1, 10);
        send_frame(w, la);
        make_frame(2000, 3, -20);
        send_frame(w, la);
        chk("b2b_wait_cycles",   w,  7);
        chk("b2b_accept_on_last", la, 1);
        chk("b2b_no_gap_valid",  out_valid, 1);
        chk("b2b_no_gap_idx",    out_idx,   order[0]);
        chk("b2b_in_ready_drop", in_ready,  0);
        wait_drain();

        // Reset while bin 4 is presented
        make_frame(3000, 5, 0);
        send_frame(w, la);
        wait_idx(4);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        frame_seq = 8'd0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_frame", out_frame, 0);
        chk("midrst_in_ready",  in_ready,  0);
        rst = 1'b1;
        make_frame(4000, 2, 100);
        send_frame(w, la);
        wait_drain();

        // Frame counter wrap: reset, then 256 frames, then one more
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        frame_seq = 8'd0;
        chk("wrap_start_frame", out_frame, 0);
        for (int f = 0; f < 256; f++) begin
            make_frame(f * 8, 1, -f);
            send_frame(w, la);
        end
        wait_drain();
        chk("wrap_frame_zero", out_frame, 0);
        chk("wrap_idle",       out_valid, 0);
        make_frame(7000, 11, 0);
        send_frame(w, la);
        wait_drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fft_out_serializer
